// File: rtl/product_collector_if.sv
// Handshake/status bundle between the upstream result source, the collector and its consumer.
// The master side drives results and consumer ready; the slave side is the collector itself.
interface product_collector_if #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             done_sig;
  logic [15:0]      product;
  logic             clr_sig;
  logic             out_ready;
  logic             out_valid;
  logic [15:0]      out_data;
  logic [LVL_W-1:0] level;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] result_cnt;
  logic             drop_sig;
  logic             acc_ovf;

  modport master (
    output done_sig, product, clr_sig, out_ready,
    input  out_valid, out_data, level, acc_sum, result_cnt, drop_sig, acc_ovf
  );

  modport slave (
    input  done_sig, product, clr_sig, out_ready,
    output out_valid, out_data, level, acc_sum, result_cnt, drop_sig, acc_ovf
  );
endinterface

// File: rtl/product_collector.sv
// Buffers done_sig-qualified products in a first-word fall-through FIFO and drains them
// over valid/ready, while keeping a signed running sum, a result count and sticky flags.
module product_collector #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  product_collector_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [15:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [15:0]      r_out_data;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_drop;
  logic             r_ovf;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [LVL_W-1:0] w_level_rem;
  logic [LVL_W-1:0] w_level_nxt;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [ACC_W-1:0] w_addend;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W-1:0] w_sum;
  logic             w_ovf;

  assign w_full      = (r_level == LVL_W'(DEPTH));
  assign w_pop       = (r_level != '0) && bus.out_ready;
  // A full buffer still accepts when the head leaves on the same edge.
  assign w_push      = bus.done_sig && (!w_full || w_pop);
  assign w_level_rem = r_level - LVL_W'(w_pop);
  assign w_level_nxt = w_level_rem + LVL_W'(w_push);
  assign w_rd_nxt    = r_rd_ptr + PTR_W'(w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.product;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_out_data <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= w_rd_nxt;
      r_level  <= w_level_nxt;
      // Head register: bypass the incoming product when nothing older survives the edge.
      if (w_level_nxt != '0) begin
        if (w_level_rem == '0) r_out_data <= bus.product;
        else                   r_out_data <= r_mem[w_rd_nxt];
      end
    end
  end

  assign w_addend = {{(ACC_W-16){bus.product[15]}}, bus.product};
  assign w_base   = bus.clr_sig ? '0 : r_acc;
  assign w_sum    = w_base + w_addend;
  assign w_ovf    = (w_base[ACC_W-1] == w_addend[ACC_W-1]) && (w_sum[ACC_W-1] != w_base[ACC_W-1]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_drop <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_acc  <= w_push ? w_sum : w_base;
      r_cnt  <= (bus.clr_sig ? '0 : r_cnt) + CNT_W'(w_push);
      // Clear takes priority over a drop or overflow on the same edge.
      r_drop <= !bus.clr_sig && (r_drop || (bus.done_sig && !w_push));
      r_ovf  <= !bus.clr_sig && (r_ovf || (w_push && w_ovf));
    end
  end

  assign bus.out_valid  = (r_level != '0);
  assign bus.out_data   = r_out_data;
  assign bus.level      = r_level;
  assign bus.acc_sum    = r_acc;
  assign bus.result_cnt = r_cnt;
  assign bus.drop_sig   = r_drop;
  assign bus.acc_ovf    = r_ovf;
endmodule

// File: doc/product_collector.md
Name: product_collector

Overview:
- Downstream stage of the divide/multiply top.
- Captures each signed 16-bit `product` qualified by the one-cycle `done_sig` pulse into a small FIFO buffer.
- Drains the buffer to a consumer over a valid/ready handshake.
- Keeps a running signed accumulation, an accepted-result count, and sticky drop/overflow flags, so a bench or host can check a batch of results without watching every pulse.

Parameters:
- DEPTH, 4, buffer entries; power of two, minimum 2.
- ACC_W, 24, accumulator width in bits; minimum 17.
- CNT_W, 8, result counter width in bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- done_sig  input  1  one-cycle pulse: `product` is valid this cycle
- product  input  16  signed two's-complement result from the upstream stage
- clr_sig  input  1  synchronous clear of statistics; buffer is not cleared
- out_ready  input  1  consumer can accept `out_data` this cycle
- out_valid  output  1  buffer non-empty; `out_data` holds the head entry
- out_data  output  16  head entry, first-word fall-through
- level  output  clog2(DEPTH)+1  current buffer occupancy, 0..DEPTH
- acc_sum  output  ACC_W  signed running sum of accepted products
- result_cnt  output  CNT_W  number of accepted products, wraps modulo 2^CNT_W
- drop_sig  output  1  sticky: a product was dropped because the buffer was full
- acc_ovf  output  1  sticky: `acc_sum` suffered signed overflow

Behaviour:
- Reset (rst_n low, asynchronous):
  - read/write pointers and level go to 0;
  - out_valid=0, out_data=0, acc_sum=0, result_cnt=0, drop_sig=0, acc_ovf=0;
  - buffer contents are don't-care.
- Push: done_sig=1 sampled at a rising edge.
  - Accepted if level<DEPTH, or if level==DEPTH and a pop occurs the same edge.
  - Otherwise the product is discarded and drop_sig sets.
- Pop: out_valid && out_ready at a rising edge; the head advances.
- Simultaneous push and pop:
  - level is unchanged;
  - data order is preserved;
  - when level==1, the new product becomes the head after the edge.
- Latency: product accepted at edge N appears on out_data with out_valid=1 from edge N onward, i.e. visible in the cycle after the pulse. There is no combinational path from done_sig to out_valid.
- out_data holds the head while out_valid=1 and out_ready=0. It must not change until popped.
- When empty, out_valid=0 and out_data holds its last value.
- Pointers are log2(DEPTH) bits and wrap naturally. level distinguishes full from empty.
- Accumulator, per accepted push:
  - acc_sum <= acc_sum + sign_extend(product, ACC_W), two's-complement wrap.
  - acc_ovf sets if the operand signs are equal and the result sign differs.
  - Dropped products are not accumulated and not counted.
- result_cnt increments by 1 per accepted push and wraps to 0 after 2^CNT_W-1.
- clr_sig=1 at an edge: acc_sum, result_cnt, drop_sig and acc_ovf clear.
- clr_sig and an accepted push at the same edge: acc_sum <= sign_extend(product), result_cnt <= 1, flags cleared. Overflow is impossible for this single term.
- clr_sig and a dropped push at the same edge: drop_sig=0 after the edge (clear wins).
- clr_sig never affects buffer contents, pointers, level or out_valid.
- done_sig held high for multiple cycles is treated as one push per cycle. Upstream guarantees single-cycle pulses; no edge detection is performed.
- Reset asserted mid-operation discards all buffered entries and statistics immediately; no partial pop occurs.

Test Plan:
- Basic stream: pulses with product 0x0016, 0x000B, 0xFFFA, out_ready=1 → out_data sequence 0x0016, 0x000B, 0xFFFA, each valid the cycle after its pulse; acc_sum=0x00001B; result_cnt=3; flags 0.
- Backpressure full: out_ready=0, five pulses with 1,2,3,4,5 → level=4, drop_sig=1, acc_sum=10, result_cnt=4; then out_ready=1 drains 1,2,3,4 and out_valid falls.
- Full with simultaneous pop: level=4, out_ready=1 and pulse with 7 at the same edge → level stays 4, drop_sig=0, and 7 is the last entry drained.
- Overflow: 257 accepted pushes of 0x7FFF, consumer always ready → after the 256th push acc_sum=0x7FFF00 and acc_ovf=0; after the 257th acc_sum wraps to 0x807EFF, acc_ovf=1, result_cnt=1.
- Clear with push: acc_sum=27, clr_sig and a pulse with 0xFFFA at the same edge → acc_sum=0xFFFFFA, result_cnt=1, flags 0, buffer still contains the earlier entries plus 0xFFFA.
- Reset mid-run: level=3, drop_sig=1, assert rst_n=0 between edges → all outputs 0 immediately; after release, a pulse with 0x0005 yields out_data=0x0005, result_cnt=1.
